param_regfile: RTL and testbench

PARAM_REGFILE -- requirements
Module: param_regfile

---
 rtl/param_regfile.sv | 60 ++++++
 tb/tb_param_regfile.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/param_regfile.sv
// Parameterised flip-flop register file: one write port, NREAD combinational read ports, optional hardwired-zero register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module param_regfile #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [NREAD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NREAD*WIDTH-1:0]      rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wrOk;

    // Writes beyond DEPTH or to the zero register are dropped, so storage never holds a stale value there.
    assign w_wrOk = wr_en && !reset && (int'(wr_addr) < DEPTH) && (int'(wr_addr) != ZERO_REG);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wrOk) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NREAD; p++) begin : g_rd
            logic [AW-1:0]    w_idx;
            logic [WIDTH-1:0] w_val;

            assign w_idx = rd_addr[p*AW +: AW];

            always_comb begin
                w_val = '0;
                if ((int'(w_idx) < DEPTH) && (int'(w_idx) != ZERO_REG)) begin
                    w_val = r_mem[w_idx];
                end
`ifdef REGFILE_BYPASS_EN
                if (w_wrOk && (wr_addr == w_idx)) begin
                    w_val = wr_data;
                end
`endif
            end

            assign rd_data[p*WIDTH +: WIDTH] = w_val;
        end
    endgenerate

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench for param_regfile: a default-parameter instance plus a DEPTH=24/NREAD=3/WIDTH=16 instance.
// Directed table, hand-written corner sequences and randomized traffic against an array-based reference model.
module tb_param_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wrEn;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [9:0]  rdAddr;
    logic [63:0] rdData;

    logic        wrEn24;
    logic [4:0]  wrAddr24;
    logic [15:0] wrData24;
    logic [14:0] rdAddr24;
    logic [47:0] rdData24;

    int errors = 0;
    int checks = 0;

    logic [31:0] refMem [32];
    logic [15:0] refMem24 [24];

    always #5 clk = ~clk;

    param_regfile dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wrEn),
        .wr_addr (wrAddr),
        .wr_data (wrData),
        .rd_addr (rdAddr),
        .rd_data (rdData)
    );

    param_regfile #(.WIDTH(16), .DEPTH(24), .NREAD(3)) dut24 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wrEn24),
        .wr_addr (wrAddr24),
        .wr_data (wrData24),
        .rd_addr (rdAddr24),
        .rd_data (rdData24)
    );

    // Reference reads: zero register and out-of-range indices read 0; optional forwarding of an accepted write.
    function automatic logic [31:0] modelRead(input int idx);
        if (idx >= 32 || idx == 31) return 32'h0;
        if (BYP && !reset && wrEn && int'(wrAddr) == idx) return wrData;
        return refMem[idx];
    endfunction

    function automatic logic [15:0] modelRead24(input int idx);
        if (idx >= 24) return 16'h0;
        if (BYP && !reset && wrEn24 && int'(wrAddr24) == idx) return wrData24;
        return refMem24[idx];
    endfunction

    task automatic clockEdge();
        @(posedge clk);
        if (reset) begin
            foreach (refMem[i]) refMem[i] = 32'h0;
            foreach (refMem24[i]) refMem24[i] = 16'h0;
        end else begin
            if (wrEn && wrAddr < 5'd31) refMem[wrAddr] = wrData;
            if (wrEn24 && wrAddr24 < 5'd24) refMem24[wrAddr24] = wrData24;
        end
        #1;
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input int wa, input logic [31:0] wd,
                                 input int ra0, input int ra1);
        reset  = rst;
        wrEn   = en;
        wrAddr = 5'(wa);
        wrData = wd;
        rdAddr = {5'(ra1), 5'(ra0)};
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        int          wa;
        logic [31:0] wd;
        int          ra0;
        int          ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5,  32'hDEADBEEF, 5,  5,  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
        vecs[1] = '{1'b0, 1'b0, 0,  32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 31, 32'h12345678, 31, 5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b0, 0,  32'h0,        31, 31, 32'h0,        32'h0};
        vecs[4] = '{1'b0, 1'b1, 7,  32'hA5A5A5A5, 5,  7,  32'hDEADBEEF, BYP ? 32'hA5A5A5A5 : 32'h0};
        vecs[5] = '{1'b0, 1'b0, 0,  32'h0,        7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6] = '{1'b0, 1'b1, 3,  32'h1,        3,  7,  BYP ? 32'h1 : 32'h0, 32'hA5A5A5A5};
        vecs[7] = '{1'b1, 1'b1, 3,  32'hFF,       3,  5,  32'h1,        32'hDEADBEEF};
        vecs[8] = '{1'b0, 1'b0, 0,  32'h0,        3,  5,  32'h0,        32'h0};
        vecs[9] = '{1'b0, 1'b0, 0,  32'h0,        7,  31, 32'h0,        32'h0};

        wrEn24 = 1'b0; wrAddr24 = '0; wrData24 = '0; rdAddr24 = '0;
        applyStimulus(1'b1, 1'b0, 0, 32'h0, 0, 0);
        clockEdge();
        clockEdge();
        applyStimulus(1'b0, 1'b0, 0, 32'h0, 0, 0);

        $display("[TB] reset sweep");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 32'h0, i, 31 - i);
            checkOutput($sformatf("reset_p0_idx%0d", i), rdData[31:0], 32'h0);
            checkOutput($sformatf("reset_p1_idx%0d", 31 - i), rdData[63:32], 32'h0);
        end

        $display("[TB] directed table");
        foreach (vecs[v]) begin
            applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].wa, vecs[v].wd, vecs[v].ra0, vecs[v].ra1);
            checkOutput($sformatf("vec%0d_p0", v), rdData[31:0], vecs[v].exp0);
            checkOutput($sformatf("vec%0d_p1", v), rdData[63:32], vecs[v].exp1);
            clockEdge();
        end

        $display("[TB] depth-24 instance");
        applyStimulus(1'b0, 1'b0, 0, 32'h0, 0, 0);
        wrEn24 = 1'b1; wrAddr24 = 5'd23; wrData24 = 16'hBEEF;
        clockEdge();
        wrAddr24 = 5'd30;
        clockEdge();
        wrEn24 = 1'b0; rdAddr24 = {5'd23, 5'd23, 5'd23};
        #1;
        for (int p = 0; p < 3; p++)
            checkOutput($sformatf("d24_reg23_p%0d", p), {16'h0, rdData24[p*16 +: 16]}, 32'h0000BEEF);
        rdAddr24 = {5'd30, 5'd23, 5'd30};
        #1;
        checkOutput("d24_idx30_p0", {16'h0, rdData24[15:0]},  32'h0);
        checkOutput("d24_reg23_p1", {16'h0, rdData24[31:16]}, 32'h0000BEEF);
        checkOutput("d24_idx30_p2", {16'h0, rdData24[47:32]}, 32'h0);
        rdAddr24 = {5'd6, 5'd7, 5'd6};
        #1;
        checkOutput("d24_alias6", {16'h0, rdData24[15:0]}, 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                          $urandom, $urandom_range(0, 31), $urandom_range(0, 31));
            wrEn24   = $urandom_range(0, 1) == 1;
            wrAddr24 = 5'($urandom_range(0, 31));
            wrData24 = 16'($urandom);
            rdAddr24 = 15'($urandom);
            #1;
            checkOutput($sformatf("rnd%0d_p0", n), rdData[31:0],  modelRead(int'(rdAddr[4:0])));
            checkOutput($sformatf("rnd%0d_p1", n), rdData[63:32], modelRead(int'(rdAddr[9:5])));
            for (int p = 0; p < 3; p++)
                checkOutput($sformatf("rnd%0d_d24_p%0d", n, p), {16'h0, rdData24[p*16 +: 16]},
                            {16'h0, modelRead24(int'(rdAddr24[p*5 +: 5]))});
            clockEdge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
